// File: rtl/cal_defs.sv
// Shared calendar constants and field widths for the date counter slice.
package cal_defs;

  localparam int unsigned MONTH_W = 4;
  localparam int unsigned DAY_W   = 5;

  localparam logic [MONTH_W-1:0] MONTH_JAN = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MONTH_APR = 4'd4;
  localparam logic [MONTH_W-1:0] MONTH_JUN = 4'd6;
  localparam logic [MONTH_W-1:0] MONTH_SEP = 4'd9;
  localparam logic [MONTH_W-1:0] MONTH_NOV = 4'd11;
  localparam logic [MONTH_W-1:0] MONTH_DEC = 4'd12;

  localparam logic [DAY_W-1:0] DAY_ONE = 5'd1;
  localparam logic [DAY_W-1:0] DAYS_28 = 5'd28;
  localparam logic [DAY_W-1:0] DAYS_29 = 5'd29;
  localparam logic [DAY_W-1:0] DAYS_30 = 5'd30;
  localparam logic [DAY_W-1:0] DAYS_31 = 5'd31;

endpackage

// File: rtl/month_length.sv
// Combinational last-day-of-month lookup; February depends on the leap flag.
module month_length
  import cal_defs::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic               leap,
  output logic [DAY_W-1:0]   last_day
);

  // Month-to-length decode
  always_comb begin
    last_day = DAYS_31;
    case (month)
      MONTH_FEB: begin
        if (leap) begin
          last_day = DAYS_29;
        end else begin
          last_day = DAYS_28;
        end
      end
      MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: last_day = DAYS_30;
      default: last_day = DAYS_31;
    endcase
  end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month calendar counter with year-rollover pulse.
// Optional `DATE_BCD_EN selects two-digit BCD on the month/day outputs.
module calendar_date_counter
  import cal_defs::*;
#(
  parameter int unsigned START_MONTH = 1,
  parameter int unsigned START_DAY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 day_tick,
  input  logic                 leap,
  input  logic                 load,
  input  logic [MONTH_W-1:0]   load_month,
  input  logic [DAY_W-1:0]     load_day,
  output logic [7:0]           month,
  output logic [7:0]           day,
  output logic                 year_carry
);

  logic [MONTH_W-1:0] month_q, month_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic               carry_q, carry_d;
  logic [DAY_W-1:0]   cur_last_s;
  logic [DAY_W-1:0]   load_last_s;
  logic               load_ok_s;

  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    if (v >= 5'd30) begin
      tens  = 4'd3;
      units = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      tens  = 4'd2;
      units = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(v - 5'd10);
    end else begin
      tens  = 4'd0;
      units = v[3:0];
    end
    return {tens, units};
  endfunction

  month_length u_cur_len (
    .month    (month_q),
    .leap     (leap),
    .last_day (cur_last_s)
  );

  month_length u_load_len (
    .month    (load_month),
    .leap     (leap),
    .last_day (load_last_s)
  );

  assign load_ok_s = (load_month >= MONTH_JAN) && (load_month <= MONTH_DEC);

  // Next-date decision: load beats tick; >= lets an out-of-range day roll over
  always_comb begin
    month_d = month_q;
    day_d   = day_q;
    carry_d = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        month_d = load_month;
        if (load_day == 5'd0) begin
          day_d = DAY_ONE;
        end else if (load_day > load_last_s) begin
          day_d = load_last_s;
        end else begin
          day_d = load_day;
        end
      end else begin
        month_d = month_q;
        day_d   = day_q;
      end
    end else if (day_tick) begin
      if (day_q < cur_last_s) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d = DAY_ONE;
        if (month_q >= MONTH_DEC) begin
          month_d = MONTH_JAN;
          carry_d = 1'b1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end else begin
      month_d = month_q;
      day_d   = day_q;
    end
  end

  // Date and carry registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      month_q <= MONTH_W'(START_MONTH);
      day_q   <= DAY_W'(START_DAY);
      carry_q <= 1'b0;
    end else begin
      month_q <= month_d;
      day_q   <= day_d;
      carry_q <= carry_d;
    end
  end

`ifdef DATE_BCD_EN
  assign month = to_bcd({1'b0, month_q});
  assign day   = to_bcd(day_q);
`else
  assign month = {4'b0000, month_q};
  assign day   = {3'b000, day_q};
`endif

  assign year_carry = carry_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed self-checking bench for calendar_date_counter (binary or BCD build).
module tb_calendar_date_counter;

  logic       clk;
  logic       rst;
  logic       day_tick;
  logic       leap;
  logic       load;
  logic [3:0] load_month;
  logic [4:0] load_day;
  logic [7:0] month;
  logic [7:0] day;
  logic       year_carry;

  int n_cmp;
  int n_err;
  logic [1:0] ly_q;

  calendar_date_counter #(.START_MONTH(1), .START_DAY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .day_tick   (day_tick),
    .leap       (leap),
    .load       (load),
    .load_month (load_month),
    .load_day   (load_day),
    .month      (month),
    .day        (day),
    .year_carry (year_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leap-year counter model enabled by year_carry
  always @(posedge clk or negedge rst) begin
    if (!rst) ly_q <= 2'd0;
    else if (year_carry) ly_q <= ly_q + 2'd1;
  end

  function automatic logic [7:0] fmt(input int v);
`ifdef DATE_BCD_EN
    return 8'(((v / 10) << 4) | (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_date(input string tag, input int m, input int d);
    check({tag, ".month"}, {8'h00, month}, {8'h00, fmt(m)});
    check({tag, ".day"}, {8'h00, day}, {8'h00, fmt(d)});
  endtask

  task automatic do_load(input int m, input int d, input logic with_tick);
    load = 1'b1;
    load_month = 4'(m);
    load_day = 5'(d);
    day_tick = with_tick;
    @(posedge clk);
    #1;
    load = 1'b0;
    day_tick = 1'b0;
  endtask

  task automatic do_tick();
    day_tick = 1'b1;
    @(posedge clk);
    #1;
    day_tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int carries;
    logic [1:0] ly_before;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    day_tick = 1'b0;
    leap = 1'b0;
    load = 1'b0;
    load_month = 4'd0;
    load_day = 5'd0;
    #12;
    check_date("reset", 1, 1);
    check("reset.carry", {15'd0, year_carry}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Asynchronous reset mid-count
    do_load(7, 15, 1'b0);
    check_date("load7_15", 7, 15);
    #2 rst = 1'b0;
    #1;
    check_date("async_rst", 1, 1);
    check("async_rst.carry", {15'd0, year_carry}, 16'd0);
    #2 rst = 1'b1;

    do_load(4, 30, 1'b0);
    do_tick();
    check_date("apr30_tick", 5, 1);
    do_load(1, 31, 1'b0);
    do_tick();
    check_date("jan31_tick", 2, 1);
    do_tick();
    check_date("feb1_tick", 2, 2);

    leap = 1'b0;
    do_load(2, 28, 1'b0);
    do_tick();
    check_date("feb28_noleap", 3, 1);
    leap = 1'b1;
    do_load(2, 28, 1'b0);
    do_tick();
    check_date("feb28_leap", 2, 29);
    do_tick();
    check_date("feb29_leap", 3, 1);

    // Leap dropping while on Feb 29
    do_load(2, 29, 1'b0);
    leap = 1'b0;
    do_tick();
    check_date("feb29_drop", 3, 1);

    // Year rollover and leap-counter enable
    do_load(12, 31, 1'b0);
    check("load_no_carry", {15'd0, year_carry}, 16'd0);
    ly_before = ly_q;
    do_tick();
    check_date("dec31_tick", 1, 1);
    check("carry_hi", {15'd0, year_carry}, 16'd1);
    idle();
    check("carry_lo", {15'd0, year_carry}, 16'd0);
    check("ly_inc", {14'd0, ly_q}, {14'd0, 2'(ly_before + 2'd1)});

    // Load edge cases
    do_load(8, 9, 1'b0);
    do_load(13, 5, 1'b0);
    check_date("load_m13", 8, 9);
    do_load(0, 5, 1'b0);
    check_date("load_m0", 8, 9);
    leap = 1'b1;
    do_load(2, 31, 1'b0);
    check_date("load_feb31_leap", 2, 29);
    leap = 1'b0;
    do_load(2, 30, 1'b0);
    check_date("load_feb30", 2, 28);
    do_load(11, 31, 1'b0);
    check_date("load_nov31", 11, 30);
    do_load(6, 0, 1'b0);
    check_date("load_d0", 6, 1);
    do_load(9, 17, 1'b1);
    check_date("load_tick", 9, 17);
    idle();
    check_date("hold", 9, 17);

    // Full non-leap year
    leap = 1'b0;
    do_load(1, 1, 1'b0);
    carries = 0;
    day_tick = 1'b1;
    for (int i = 1; i <= 365; i++) begin
      @(posedge clk);
      #1;
      if (year_carry) carries++;
      if (i == 30) check_date("jan31", 1, 31);
      if (i == 59) check_date("mar1", 3, 1);
    end
    day_tick = 1'b0;
    check_date("year365", 1, 1);
    check("year365_carries", 16'(carries), 16'd1);
    idle();
    check("year365_carry_lo", {15'd0, year_carry}, 16'd0);

    // Full leap year needs 366 ticks
    leap = 1'b1;
    carries = 0;
    day_tick = 1'b1;
    for (int i = 1; i <= 365; i++) begin
      @(posedge clk);
      #1;
      if (year_carry) carries++;
      if (i == 59) check_date("leap_feb29", 2, 29);
    end
    day_tick = 1'b0;
    check_date("leap365", 12, 31);
    check("leap365_carries", 16'(carries), 16'd0);
    do_tick();
    check_date("leap366", 1, 1);
    check("leap366_carry", {15'd0, year_carry}, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Day/month calendar stage directly upstream of the 2-bit leap-year counter.
- Advances the date by one day per `day_tick`. Uses the leap flag decoded from the leap-year counter to size February.
- Emits a one-cycle `year_carry` pulse on Dec 31 -> Jan 1 rollover. That pulse drives the leap-year counter's `enable`.
- Outputs feed the seven-segment date display.

Parameters:
- START_MONTH, 1, month value after reset (1..12).
- START_DAY, 1, day value after reset (1..31; must be valid for START_MONTH in a non-leap year).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- day_tick  input  1  one-cycle strobe: advance date by one day.
- leap  input  1  1 = current year is leap (leap-year counter q == 0), sampled combinationally.
- load  input  1  one-cycle strobe: load load_month/load_day.
- load_month  input  4  binary month for load, 1..12.
- load_day  input  5  binary day for load, 1..31.
- month  output  8  current month; binary in [3:0] with [7:4]=0, or BCD when DATE_BCD_EN is defined.
- day  output  8  current day; binary in [4:0] with [7:5]=0, or BCD when DATE_BCD_EN is defined.
- year_carry  output  1  registered one-cycle pulse on year rollover.

Behaviour:
- Reset (rst low, asynchronous): month=START_MONTH, day=START_DAY, year_carry=0. Holds while rst low; the first clk edge after release applies normal rules.
- last_day(m, leap):
  - Feb: 29 if leap, else 28.
  - Apr/Jun/Sep/Nov: 30.
  - All other months: 31.
- Priority per clk edge: load > day_tick > hold.
- day_tick, day < last_day: day+1, month unchanged.
- day_tick, day >= last_day: day=1, month+1.
  - Uses >=, so an out-of-range day (e.g. Feb 29 after leap drops) rolls to Mar 1.
- day_tick on Dec 31 (or Dec >= last_day): month=1, day=1, year_carry=1 in the following cycle only.
- year_carry:
  - Registered, one clk wide. Deasserted on every cycle with no rollover.
  - Back-to-back rollovers are impossible: a minimum of 365 ticks separates them.
- load:
  - load_month outside 1..12 -> load ignored entirely; date holds.
  - load_day of 0 -> day=1.
  - load_day > last_day(load_month, leap) -> day clamped to last_day.
  - Load never asserts year_carry.
- load and day_tick in the same cycle: load wins and the tick is dropped.
- Latency: date outputs update one clk after the strobe. year_carry is visible one clk after the Dec 31 tick.
- leap changing mid-year takes effect on the next tick decision. No retroactive correction.
- Internal state is always binary; conversion to output format is combinational from registers.

Optional Feature:
- Macro: DATE_BCD_EN.
- Defined: month and day outputs are two-digit BCD (tens in [7:4], units in [3:0]), e.g. day 29 -> 8'h29, month 12 -> 8'h12.
- Not defined: plain zero-extended binary, e.g. day 29 -> 8'd29.
- Internal counting, year_carry and load semantics are identical in both builds.

Decomposition:
- Shared package/header cal_defs holds:
  - month constants: MONTH_JAN=1, MONTH_FEB=2, MONTH_DEC=12;
  - day limits: DAYS_28/29/30/31;
  - field widths: MONTH_W=4, DAY_W=5.
- One combinational sub-module, month_length: inputs month[3:0] and leap; output last_day[4:0].
  - Instantiated twice: once for the current month, once for load_month during clamp.
- BCD conversion is an inline function, not a sub-module.

Test Plan:
- Reset: pulse rst low mid-count on Jul 15 -> month=7? no: month=1, day=1, year_carry=0 immediately, without waiting for clk.
- Month lengths: load 4/30, one tick -> 5/1; load 1/31, one tick -> 2/1.
- February: load 2/28, leap=0, one tick -> 3/1. Repeat with leap=1 -> 2/29, then one more tick -> 3/1.
- Year rollover: load 12/31, tick -> 1/1 and year_carry high exactly one cycle. Connect a leap-year counter model and check its q increments by 1.
- Load edge cases:
  - load 13/05 -> date unchanged.
  - load 2/31, leap=1 -> 2/29.
  - load 6/0 -> 6/1.
  - load together with day_tick -> loaded value, no increment.
- Full year, DATE_BCD_EN defined:
  - 365 ticks from 1/1, leap=0 -> back to 1/1 with exactly one year_carry.
  - day output 8'h31 observed on Jan 31.
  - 366 ticks are needed with leap=1.
